// File: rtl/dual_port_dmem_responder.sv
// Two-port synchronous data memory responder: clears the array after reset, then serves
// independent load/store ports with write-first, cross-port bypass and port-b-wins arbitration.
module dual_port_dmem_responder #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [ADDR_W-1:0] address_b,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    input  logic              wren_a,
    input  logic              wren_b,
    output logic [DATA_W-1:0] q_a,
    output logic [DATA_W-1:0] q_b,
    output logic              ready,
    output logic              collision
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] ptr_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              same_addr_s;
    logic              dual_hit_s;
    logic              commit_a_s;
    logic              commit_b_s;
    logic              sweep_done_s;
    logic [DATA_W-1:0] rd_a_s;
    logic [DATA_W-1:0] rd_b_s;

    // Write arbitration and write-first read selection (port b is younger, so it wins).
    always_comb begin
        same_addr_s  = (address_a == address_b);
        dual_hit_s   = wren_a && wren_b && same_addr_s;
        sweep_done_s = (ptr_r == ADDR_W'(DEPTH - 2));
        if (state_r == ST_RUN) begin
            commit_a_s = wren_a && !dual_hit_s;
            commit_b_s = wren_b;
        end else begin
            commit_a_s = 1'b0;
            commit_b_s = 1'b0;
        end
        if (wren_b && same_addr_s) begin
            rd_a_s = data_b;
        end else if (wren_a) begin
            rd_a_s = data_a;
        end else begin
            rd_a_s = mem_r[address_a];
        end
        if (wren_b) begin
            rd_b_s = data_b;
        end else if (wren_a && same_addr_s) begin
            rd_b_s = data_a;
        end else begin
            rd_b_s = mem_r[address_b];
        end
    end

    // Word array: two zero writes per edge while clearing, otherwise the committed stores.
    always_ff @(posedge clock) begin
        if (state_r == ST_CLEAR) begin
            mem_r[ptr_r]                <= {DATA_W{1'b0}};
            mem_r[ptr_r + ADDR_W'(1)]   <= {DATA_W{1'b0}};
        end else begin
            if (commit_a_s) begin
                mem_r[address_a] <= data_a;
            end
            if (commit_b_s) begin
                mem_r[address_b] <= data_b;
            end
        end
    end

    // Sweep/run controller with registered read data, ready and collision flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= ST_CLEAR;
            ptr_r     <= {ADDR_W{1'b0}};
            q_a       <= {DATA_W{1'b0}};
            q_b       <= {DATA_W{1'b0}};
            ready     <= 1'b0;
            collision <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    q_a       <= {DATA_W{1'b0}};
                    q_b       <= {DATA_W{1'b0}};
                    collision <= 1'b0;
                    ptr_r     <= ptr_r + ADDR_W'(2);
                    if (sweep_done_s) begin
                        state_r <= ST_RUN;
                        ready   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    q_a       <= rd_a_s;
                    q_b       <= rd_b_s;
                    collision <= dual_hit_s;
                    ready     <= 1'b1;
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    ptr_r     <= {ADDR_W{1'b0}};
                    q_a       <= {DATA_W{1'b0}};
                    q_b       <= {DATA_W{1'b0}};
                    ready     <= 1'b0;
                    collision <= 1'b0;
                end
            endcase
        end
    end

endmodule
